test_value_display: RTL and testbench

- Output stage directly downstream of the pipelined MIPS top. Consumes its 16-bit test_value and drives a 4-digit multiplexed common-anode seven-segment display.
- Snapshots test_value once per scan frame so all four digits always show one consistent value.
- Supports a freeze (hold) input and emits a pulse when the displayed value changes.

---
 rtl/test_value_display_if.sv | 13 +
 rtl/test_value_display.sv | 110 +++++++++++
 tb/tb_test_value_display.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/test_value_display_if.sv
// Bundle between the value source and the seven-segment display driver.
// The source side uses the master modport and the display uses the slave modport.
interface test_value_display_if;
  logic [15:0] test_value;
  logic        hold;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        changed;

  modport master (output test_value, hold, input an, seg, dp, changed);
  modport slave  (input test_value, hold, output an, seg, dp, changed);
endinterface

// File: rtl/test_value_display.sv
// Drives a 4-digit multiplexed common-anode display, snapshotting test_value once per frame.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits; digit 0 is never blanked.
module test_value_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic             clk,
  input logic             reset,
  test_value_display_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TICK_VAL = CW'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_dig;
  logic [15:0]   r_shadow;
  logic          r_first;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_changed;

  logic          w_tick;
  logic          w_frame;
  logic          w_load;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_seg;

  // Frame timing and segment pattern for the digit currently being scanned.
  always_comb begin
    w_tick   = (r_div_cnt == TICK_VAL);
    w_frame  = r_first | (w_tick & (r_dig == 2'd3));
    w_load   = w_frame & ~bus.hold;
    w_nibble = r_shadow[{r_dig, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    case (r_dig)
      2'd1:    w_blank = (r_shadow[15:4]  == 12'h000);
      2'd2:    w_blank = (r_shadow[15:8]  == 8'h00);
      2'd3:    w_blank = (r_shadow[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank = 1'b0;
`endif
    if (w_blank) begin
      w_seg = 7'h7F;
    end else begin
      w_seg = hex7(w_nibble);
    end
  end

  // Scan counters, snapshot register and the registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_dig     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_first   <= 1'b1;
      r_an      <= 4'b1111;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_changed <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_dig     <= r_dig + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + CW'(1);
      end
      r_first <= 1'b0;
      if (w_load) begin
        r_shadow <= bus.test_value;
      end
      r_changed <= w_load & (bus.test_value != r_shadow);
      r_an      <= ~(4'b0001 << r_dig);
      r_seg     <= w_seg;
      // Decimal point on digit 0 signals a frozen display.
      r_dp      <= ~(bus.hold & (r_dig == 2'd0));
    end
  end

  assign bus.an      = r_an;
  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.changed = r_changed;
endmodule

// File: tb/tb_test_value_display.sv
// Scoreboard bench for test_value_display with REFRESH_DIV = 4.
// Each driven cycle pushes the expected {an,seg,dp,changed}; the test tasks pop and compare.
module tb_test_value_display;
  logic clk = 1'b0;
  logic reset = 1'b1;

  test_value_display_if bus ();

  test_value_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] hex7_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [12:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          m_t = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [12:0] obs;
  logic [12:0] exp_v;

  // Drive one cycle and push what the display should show after the coming edge.
  task automatic cycle(input logic [15:0] tv, input logic h, input logic rst);
    logic [1:0]  d;
    logic        frame;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic [15:0] upper;
    logic        dp_e;
    logic        chg_e;
    @(negedge clk);
    reset = rst;
    bus.test_value = tv;
    bus.hold = h;
    if (rst) begin
      sb_q.push_back({4'b1111, 7'h7F, 1'b1, 1'b0});
      m_t = 0;
      m_shadow = 16'h0000;
    end else begin
      d = 2'((m_t / 4) % 4);
      frame = (m_t == 0) || (m_t % 16 == 15);
      an_e = 4'b1111 ^ (4'b0001 << d);
      upper = m_shadow >> {d, 2'b00};
      seg_e = hex7_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 2'd0 && upper == 16'h0000) seg_e = 7'h7F;
`endif
      dp_e = !(h && d == 2'd0);
      chg_e = frame && !h && (tv != m_shadow);
      if (frame && !h) m_shadow = tv;
      m_t++;
      sb_q.push_back({an_e, seg_e, dp_e, chg_e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(16'h1234, 1'b0, 1'b1);
      obs = {bus.an, bus.seg, bus.dp, bus.changed};
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset cyc=%0d got an|seg|dp|chg=%b required=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_steady();
    int pulses = 0;
    for (int i = 0; i < 47; i++) begin
      cycle(16'h1234, 1'b0, 1'b0);
      obs = {bus.an, bus.seg, bus.dp, bus.changed};
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL steady t=%0d got an|seg|dp|chg=%b required=%b", i, obs, exp_v);
      end
      if (bus.changed) pulses++;
      if (i == 5) begin
        checks++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'b0110000) begin
          errors++;
          $display("FAIL steady_digit1 got an=%b seg=%b required an=1101 seg=0110000", bus.an, bus.seg);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL steady_pulses got %0d required 1", pulses);
    end
  endtask

  // Hold rises exactly on a frame boundary, is kept for 3+ frames, then drops mid-frame.
  task automatic test_hold();
    int pulses = 0;
    int pulse_t = -1;
    int t;
    int dp_low = 0;
    for (int i = 0; i < 86; i++) begin
      t = m_t;
      cycle(16'hABCD, (i < 54) ? 1'b1 : 1'b0, 1'b0);
      obs = {bus.an, bus.seg, bus.dp, bus.changed};
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold t=%0d got an|seg|dp|chg=%b required=%b", t, obs, exp_v);
      end
      if (bus.changed) begin
        pulses++;
        pulse_t = t;
      end
      if (!bus.dp) dp_low++;
      if (t == 124) begin
        checks++;
        if (bus.an !== 4'b0111 || bus.seg !== 7'b0001000) begin
          errors++;
          $display("FAIL hold_digit3 got an=%b seg=%b required an=0111 seg=0001000", bus.an, bus.seg);
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_t != 111) begin
      errors++;
      $display("FAIL hold_release_pulse got count=%0d at t=%0d required count=1 at t=111", pulses, pulse_t);
    end
    checks++;
    if (dp_low == 0) begin
      errors++;
      $display("FAIL hold_dp got %0d lit cycles required nonzero", dp_low);
    end
  endtask

  task automatic test_same_value();
    int pulses = 0;
    for (int i = 0; i < 48; i++) begin
      cycle(16'hABCD, 1'b0, 1'b0);
      obs = {bus.an, bus.seg, bus.dp, bus.changed};
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL same_value i=%0d got an|seg|dp|chg=%b required=%b", i, obs, exp_v);
      end
      if (bus.changed) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL same_value_pulses got %0d required 0", pulses);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (((m_t / 4) % 4) != 2 && guard < 16) begin
      cycle(16'hABCD, 1'b0, 1'b0);
      void'(sb_q.pop_front());
      guard++;
    end
    cycle(16'hABCD, 1'b0, 1'b0);
    obs = {bus.an, bus.seg, bus.dp, bus.changed};
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v || bus.an !== 4'b1011) begin
      errors++;
      $display("FAIL mid_reset_pre got an|seg|dp|chg=%b required=%b", obs, exp_v);
    end
    cycle(16'hABCD, 1'b0, 1'b1);
    obs = {bus.an, bus.seg, bus.dp, bus.changed};
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_assert got an|seg|dp|chg=%b required=%b", obs, exp_v);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(16'hABCD, 1'b0, 1'b0);
      obs = {bus.an, bus.seg, bus.dp, bus.changed};
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mid_reset_resume i=%0d got an|seg|dp|chg=%b required=%b", i, obs, exp_v);
      end
      if (i < 5) begin
        checks++;
        if (bus.an !== ((i < 4) ? 4'b1110 : 4'b1101)) begin
          errors++;
          $display("FAIL mid_reset_slot i=%0d got an=%b required %b", i, bus.an, (i < 4) ? 4'b1110 : 4'b1101);
        end
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    logic [15:0] vals [3];
    vals[0] = 16'h0005;
    vals[1] = 16'h0000;
    vals[2] = 16'h0100;
    cycle(16'h0005, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 32; i++) begin
        cycle(vals[v], 1'b0, 1'b0);
        obs = {bus.an, bus.seg, bus.dp, bus.changed};
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL blank val=%h i=%0d got an|seg|dp|chg=%b required=%b", vals[v], i, obs, exp_v);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.test_value = 16'h0000;
    bus.hold = 1'b0;
    test_reset();
    test_steady();
    test_hold();
    test_same_value();
    test_mid_reset();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
